// File: rtl/mem_ss_arb.sv
// mem_ss_arb: two-requester round-robin arbiter in front of a single AHB-Lite
// master port. One transfer at a time walks IDLE -> ADDR -> DATA -> RESP.
// Optional build macro MEM_SS_ARB_TIMEOUT_EN adds a DATA-phase HREADY timeout
// that forces an error completion after TIMEOUT_CYC wait cycles.
module mem_ss_arb #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req,
  input  logic [1:0]  write,
  input  logic [61:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [30:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  output logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state;
  logic        last_gnt;
  logic [31:0] lat_wdata;
  logic        winner;
  logic        sel_write;
  logic [30:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        timeout;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_gnt;
    end else if (req[1]) begin
      winner = 1'b1;
    end
    sel_write = write[winner];
    sel_addr  = winner ? addr[61:31] : addr[30:0];
    sel_wdata = winner ? wdata[63:32] : wdata[31:0];
  end

`ifdef MEM_SS_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] to_cnt;

  // The final wait cycle is the one where the counter is about to reach TIMEOUT_CYC.
  assign timeout = (to_cnt == CntW'(TIMEOUT_CYC - 1));

  // Count DATA cycles spent waiting for HREADY; cleared on the way into DATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt <= '0;
    end else if (state == ADDR) begin
      to_cnt <= '0;
    end else if (state == DATA && !HREADY) begin
      to_cnt <= to_cnt + CntW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Transfer sequencer; every output is produced here so all outputs are registered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lat_wdata <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HTRANS    <= 2'b00;
      HSIZE     <= 3'b000;
      HBURST    <= 3'b000;
      HPROT     <= 4'b0000;
      HWDATA    <= '0;
      HSEL      <= 1'b0;
    end else begin
      HSIZE  <= 3'b010;
      HBURST <= 3'b000;
      HPROT  <= 4'b0011;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= ADDR;
            last_gnt  <= winner;
            lat_wdata <= sel_wdata;
            HADDR     <= sel_addr;
            HWRITE    <= sel_write;
            HTRANS    <= 2'b10;
            HSEL      <= 1'b1;
          end
        end
        ADDR: begin
          state  <= DATA;
          HTRANS <= 2'b00;
          HWDATA <= lat_wdata;
        end
        DATA: begin
          if (HREADY || timeout) begin
            state <= RESP;
            HSEL  <= 1'b0;
            ack   <= last_gnt ? 2'b10 : 2'b01;
            rdata <= (HREADY && !HWRITE) ? HRDATA : 32'h0;
            err   <= !HREADY || (HRESP != 2'b00);
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 2'b00;
          rdata <= 32'h0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ss_arb.sv
// tb_mem_ss_arb: self-checking bench for mem_ss_arb. The bench plays both
// requesters and a memory-backed AHB slave; expected values come from a
// transfer-level model (round-robin rule plus a word memory).
module tb_mem_ss_arb;

  localparam int TIMEOUT_CYC = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  req;
  logic [1:0]  write;
  logic [61:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [30:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  int checks = 0;
  int failures = 0;

  logic [31:0] slave_mem [bit [30:0]];
  logic [31:0] model_mem [bit [30:0]];
  int          model_last;

  typedef struct {
    bit          do_reset;
    logic [1:0]  req;
    logic [1:0]  write;
    logic [30:0] addr0;
    logic [30:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  resp;
    int          waits;
    int          exp_gnt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  mem_ss_arb #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .HADDR(HADDR),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HSEL(HSEL), .HREADY(HREADY),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  // Free-running clock.
  always #5 HCLK = ~HCLK;

  // Two requesters must never be acknowledged together.
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1) begin
      checks++;
      if (ack === 2'b11) begin
        failures++;
        $display("[TB] FAIL ack_exclusive: got=%b expected one-hot or zero", ack);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] defaultWord(input logic [30:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [127:0] allOutputs();
    return {16'h0, ack, rdata, err, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HSEL};
  endfunction

  function automatic vec_t mkVec(input bit rst, input logic [1:0] rq, input logic [1:0] wr,
                                 input logic [30:0] a0, input logic [30:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] rs, input int wt, input int g,
                                 input logic [31:0] rd, input logic e);
    vec_t v;
    v.do_reset = rst; v.req = rq; v.write = wr; v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = d0; v.wdata1 = d1; v.resp = rs; v.waits = wt; v.exp_gnt = g;
    v.exp_rdata = rd; v.exp_err = e;
    return v;
  endfunction

  task automatic applyReset();
    HRESETn = 1'b0;
    req = 2'b00;
    HREADY = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    write = v.write;
    addr  = {v.addr1, v.addr0};
    wdata = {v.wdata1, v.wdata0};
  endtask

  // Run one transfer from IDLE with the slave inserting `waits` wait states.
  task automatic runTransfer(input int exp_gnt, input int waits, input logic [1:0] resp,
                             input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int          n;
    logic [30:0] exp_addr;
    logic        exp_write;
    logic [31:0] exp_wdata;
    logic [30:0] a_cap;
    logic        w_cap;
    logic [31:0] d_cap;
    exp_addr  = (exp_gnt == 1) ? addr[61:31] : addr[30:0];
    exp_write = write[exp_gnt];
    exp_wdata = (exp_gnt == 1) ? wdata[63:32] : wdata[31:0];
    n = 0;
    do begin
      step();
      n++;
    end while (HTRANS !== 2'b10 && n < 8);
    checkOutput({tag, ".nonseq"}, HTRANS, 2'b10);
    if (HTRANS !== 2'b10) return;
    checkOutput({tag, ".grant_latency"}, n, 1);
    checkOutput({tag, ".addr_phase"}, {HSEL, HWRITE, HADDR, HSIZE, HBURST, HPROT, ack},
                {1'b1, exp_write, exp_addr, 3'b010, 3'b000, 4'b0011, 2'b00});
    a_cap = HADDR;
    w_cap = HWRITE;
    step();
    checkOutput({tag, ".data_phase"}, {HTRANS, HSEL, ack}, {2'b00, 1'b1, 2'b00});
    if (exp_write) checkOutput({tag, ".hwdata"}, HWDATA, exp_wdata);
    d_cap = HWDATA;
    HREADY = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step();
      checkOutput({tag, ".wait_no_ack"}, {HTRANS, HSEL, ack}, {2'b00, 1'b1, 2'b00});
    end
    HREADY = 1'b1;
    HRESP  = resp;
    HRDATA = w_cap ? $urandom : (slave_mem.exists(a_cap) ? slave_mem[a_cap] : defaultWord(a_cap));
    step();
    HREADY = 1'b0;
    HRESP  = 2'b00;
    if (w_cap && resp == 2'b00) slave_mem[a_cap] = d_cap;
    checkOutput({tag, ".ack"}, ack, (exp_gnt == 1) ? 2'b10 : 2'b01);
    checkOutput({tag, ".rdata"}, rdata, exp_rdata);
    checkOutput({tag, ".err"}, err, exp_err);
    req[exp_gnt] = 1'b0;
    step();
    checkOutput({tag, ".idle"}, {ack, rdata, err, HTRANS, HSEL}, 38'h0);
  endtask

  task automatic newRequest(input int r);
    req[r]            = 1'b1;
    write[r]          = 1'($urandom_range(0, 1));
    addr[r*31 +: 31]  = 31'($urandom_range(0, 7) * 4 + 32'h400);
    wdata[r*32 +: 32] = $urandom;
  endtask

  initial begin
    int          gnt;
    int          waits;
    int          ack_seen;
    logic [30:0] a;
    logic        w;
    logic [31:0] d;
    logic [1:0]  resp;
    logic        e;
    logic [31:0] exp_rd;

    req = 2'b00; write = 2'b00; addr = '0; wdata = '0;
    HREADY = 1'b0; HRDATA = '0; HRESP = 2'b00;

    vecs.push_back(mkVec(1, 2'b01, 2'b01, 31'h100, 31'h0,   32'hA5A5_0001, 32'h0,         2'b00, 1, 0, 32'h0,         1'b0));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 31'h100, 31'h0,   32'h0,         32'h0,         2'b00, 0, 0, 32'hA5A5_0001, 1'b0));
    vecs.push_back(mkVec(1, 2'b11, 2'b11, 31'h200, 31'h204, 32'h1111_0000, 32'h2222_0000, 2'b00, 0, 0, 32'h0,         1'b0));
    vecs.push_back(mkVec(0, 2'b11, 2'b10, 31'h204, 31'h204, 32'h0,         32'h2222_0000, 2'b00, 2, 1, 32'h0,         1'b0));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 31'h204, 31'h200, 32'h0,         32'h0,         2'b00, 0, 0, 32'h2222_0000, 1'b0));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 31'h204, 31'h200, 32'h0,         32'h0,         2'b00, 1, 1, 32'h1111_0000, 1'b0));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 31'h204, 31'h0,   32'h0,         32'h0,         2'b00, 0, 0, 32'h2222_0000, 1'b0));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 31'h0,   31'h100, 32'h0,         32'h0,         2'b01, 0, 1, 32'hA5A5_0001, 1'b1));
    vecs.push_back(mkVec(0, 2'b01, 2'b01, 31'h100, 31'h0,   32'hDEAD_BEEF, 32'h0,         2'b11, 0, 0, 32'h0,         1'b1));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 31'h0,   31'h100, 32'h0,         32'h0,         2'b00, 0, 1, 32'hA5A5_0001, 1'b0));

    $display("[TB] reset state");
    HRESETn = 1'b0;
    #3;
    checkOutput("reset_outputs", allOutputs(), 128'h0);
    step();
    HRESETn = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) applyReset();
      applyStimulus(vecs[i]);
      runTransfer(vecs[i].exp_gnt, vecs[i].waits, vecs[i].resp, vecs[i].exp_rdata,
                  vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    $display("[TB] HREADY held low");
    req = 2'b01; write = 2'b00; addr = {31'h0, 31'h100};
    HREADY = 1'b0; HRDATA = 32'hFFFF_FFFF; HRESP = 2'b00;
    step();
    checkOutput("stall.nonseq", HTRANS, 2'b10);
    step();
    ack_seen = 0;
`ifdef MEM_SS_ARB_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT_CYC; k++) begin
      step();
      if (ack !== 2'b00) ack_seen++;
    end
    checkOutput("stall.no_early_ack", ack_seen, 0);
    step();
    checkOutput("stall.timeout_ack", {ack, err, rdata}, {2'b01, 1'b1, 32'h0});
    req = 2'b00;
    step();
    checkOutput("stall.back_to_idle", {ack, err, HSEL, HTRANS}, 6'h0);
`else
    for (int k = 0; k < 100; k++) begin
      step();
      if (ack !== 2'b00) ack_seen++;
    end
    checkOutput("stall.no_ack_100", ack_seen, 0);
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    step();
    HREADY = 1'b0;
    checkOutput("stall.late_ack", {ack, err, rdata}, {2'b01, 1'b0, 32'h1234_5678});
    req = 2'b00;
    step();
    checkOutput("stall.back_to_idle", {ack, err, HSEL, HTRANS}, 6'h0);
`endif

    $display("[TB] reset during DATA");
    req = 2'b01; write = 2'b01; addr = {31'h0, 31'h300}; wdata = {32'h0, 32'h7777_7777};
    step();
    checkOutput("rst_mid.nonseq", HTRANS, 2'b10);
    step();
    step();
    checkOutput("rst_mid.in_data", {HSEL, ack}, {1'b1, 2'b00});
    HRESETn = 1'b0;
    #1;
    checkOutput("rst_mid.outputs_zero", allOutputs(), 128'h0);
    req = 2'b00;
    step();
    step();
    checkOutput("rst_mid.held", allOutputs(), 128'h0);
    HRESETn = 1'b1;
    step();
    checkOutput("rst_mid.no_ack", {ack, HTRANS}, 4'h0);
    req = 2'b10; write = 2'b00; addr = {31'h200, 31'h0};
    runTransfer(1, 0, 2'b00, 32'h1111_0000, 1'b0, "rst_mid.r1_read");
    checkOutput("rst_mid.abandoned_write", slave_mem.exists(31'h300), 1'b0);

    $display("[TB] randomized transfers");
    applyReset();
    slave_mem.delete();
    model_mem.delete();
    model_last = 1;
    req = 2'b00;
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req[r] && $urandom_range(0, 3) != 0) newRequest(r);
      end
      if (req == 2'b00) newRequest(int'($urandom_range(0, 1)));
      if (req == 2'b11) gnt = 1 - model_last;
      else gnt = req[1] ? 1 : 0;
      a = (gnt == 1) ? addr[61:31] : addr[30:0];
      w = write[gnt];
      d = (gnt == 1) ? wdata[63:32] : wdata[31:0];
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      waits = int'($urandom_range(0, 4));
      e = (resp != 2'b00);
      exp_rd = w ? 32'h0 : (model_mem.exists(a) ? model_mem[a] : defaultWord(a));
      runTransfer(gnt, waits, resp, exp_rd, e, $sformatf("rand%0d", t));
      if (w && !e) model_mem[a] = d;
      model_last = gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ss_arb.md
MEM_SS_ARB -- requirements
Module: mem_ss_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum number of DATA-state cycles to wait for HREADY before a forced error completion.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 HCLK  input  1  clock; all state changes on its rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 req  input  2  per-requester transfer request; bit i = requester i.
REQ-006 write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 addr  input  62  packed requester addresses; [30:0] = requester 0, [61:31] = requester 1.
REQ-008 wdata  input  64  packed requester write data; [31:0] = requester 0, [63:32] = requester 1.
REQ-009 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  32  read data, valid while ack is high.
REQ-011 err  output  1  error flag, valid while ack is high.
REQ-012 HADDR  output  31  AHB address.
REQ-013 HWRITE  output  1  AHB direction.
REQ-014 HTRANS  output  2  AHB transfer type.
REQ-015 HSIZE  output  3  fixed at 3'b010 (word).
REQ-016 HBURST  output  3  fixed at 3'b000 (single).
REQ-017 HPROT  output  4  fixed at 4'b0011.
REQ-018 HWDATA  output  32  AHB write data.
REQ-019 HSEL  output  1  slave select.
REQ-020 HREADY  input  1  slave transfer complete.
REQ-021 HRDATA  input  32  slave read data.
REQ-022 HRESP  input  2  slave response; any value other than 2'b00 is an error.

Function
REQ-023 The FSM SHALL have four states: IDLE, ADDR, DATA, RESP.
- IDLE to ADDR on any req bit high.
- ADDR to DATA unconditionally.
- DATA to RESP when HREADY=1, or on timeout.
- RESP to IDLE unconditionally.
REQ-024 Round-robin arbitration in IDLE.
- When both requests are high, the requester not granted last wins.
- When only one request is high, that requester wins.
- On the IDLE-to-ADDR edge, the winner's write, addr and wdata are latched and it becomes the last-granted requester.
REQ-025 ADDR state (exactly one cycle): HTRANS=2'b10 (NONSEQ), HSEL=1, HADDR and HWRITE from the latched values.
REQ-026 HTRANS SHALL be 2'b00 in all other states.
REQ-027 DATA state: HSEL=1, HWDATA = latched wdata; HREADY is sampled only in DATA.
REQ-028 On the DATA-to-RESP edge:
- rdata <= HRDATA if the transfer was a read, else 0;
- err <= (HRESP != 2'b00).
REQ-029 RESP state: ack[granted]=1 for exactly one cycle; req is ignored.
- The requester holds req/write/addr/wdata stable until it samples ack, then drops req.
- Minimum transfer: 4 cycles from request to IDLE.
REQ-030 HSEL and ack SHALL be 0 in IDLE.
- HADDR, HWRITE and HWDATA hold their last values.
- rdata and err SHALL be 0 outside RESP.
REQ-031 The request vector is sampled only in IDLE; a request raised in any other state waits.
REQ-032 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-033 While HRESETn=0, asynchronously: state=IDLE, all outputs 0, timeout counter 0, last-granted = requester 1 (so requester 0 wins the first tie).
REQ-034 A reset mid-transfer abandons the transfer with no ack; the first request after reset release is serviced normally.

Configuration
REQ-035 With MEM_SS_ARB_TIMEOUT_EN defined:
- a counter clears on entry to DATA and increments each DATA cycle with HREADY=0;
- when it reaches TIMEOUT_CYC, the FSM moves to RESP with err=1 and rdata=0.
REQ-036 Without MEM_SS_ARB_TIMEOUT_EN: no counter is built, and DATA waits indefinitely for HREADY.

Verification
REQ-037 Requester 0 writes addr 0x00000100, data 0xA5A5_0001, then reads the same address.
- HTRANS is NONSEQ for exactly 1 cycle per transfer.
- ack[0] pulses once per transfer.
- The read returns rdata=0xA5A5_0001 with err=0.
REQ-038 Both req bits are held high for 4 transfers starting from reset -> grant order 0,1,0,1; ack[0] and ack[1] are never high together.
REQ-039 Slave returns HRESP=2'b01 with HREADY=1 on a requester-1 read -> ack[1]=1 with err=1 in the same cycle.
REQ-040 HREADY is held 0 with TIMEOUT_CYC=16.
- With macro: ack with err=1 after the 16th DATA cycle, then the FSM returns to IDLE.
- Without macro: no ack within 100 cycles; raising HREADY then completes the transfer.
REQ-041 HRESETn is pulsed low during DATA -> all outputs 0 immediately and no ack; after release, a requester-1 read completes in 4 cycles.
